// File: rtl/mac_sequencer.sv
// Sequences one MAC PE job: fetch len operand pairs, flush the PE, capture and hand off the result.
// Optional build macro MAC_SEQ_RELU_EN applies a ReLU to the captured result.
module mac_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [ADDR_W-1:0] start_base_a,
    input  logic [ADDR_W-1:0] start_base_b,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] mac_inputa,
    output logic [DATA_W-1:0] mac_inputb,
    output logic              mac_output_en,
    input  logic [DATA_W-1:0] mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FLUSH,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t              state_reg, state_next;
    logic [LEN_W-1:0]    len_reg;
    logic [LEN_W-1:0]    k_reg;
    logic [ADDR_W-1:0]   base_a_reg;
    logic [ADDR_W-1:0]   base_b_reg;
    logic                drain_cnt_reg;
    logic                rd_pend_reg;
    logic [DATA_W-1:0]   inputa_reg;
    logic [DATA_W-1:0]   inputb_reg;
    logic                out_en_reg;
    logic                res_valid_reg;
    logic [DATA_W-1:0]   res_data_reg;
    logic                busy_reg;
    logic [DATA_W-1:0]   res_capture;

`ifdef MAC_SEQ_RELU_EN
    // Negative two's-complement results are clamped to zero bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_relu
            assign res_capture[gi] = mac_result[gi] & ~mac_result[DATA_W-1];
        end
    endgenerate
`else
    assign res_capture = mac_result;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:    if (out_en_reg) state_next = S_IDLE;
            S_IDLE:    if (start_valid) state_next = (start_len == '0) ? S_DRAIN : S_FETCH;
            S_FETCH:   if (k_reg == len_reg - LEN_W'(1)) state_next = S_DRAIN;
            S_DRAIN:   if (drain_cnt_reg) state_next = S_FLUSH;
            S_FLUSH:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_HOLD;
            S_HOLD:    if (res_ready) state_next = S_IDLE;
            default:   state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_INIT;
            len_reg       <= '0;
            k_reg         <= '0;
            base_a_reg    <= '0;
            base_b_reg    <= '0;
            drain_cnt_reg <= 1'b0;
            rd_pend_reg   <= 1'b0;
            inputa_reg    <= '0;
            inputb_reg    <= '0;
            out_en_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && start_valid) begin
                len_reg    <= start_len;
                base_a_reg <= start_base_a;
                base_b_reg <= start_base_b;
                k_reg      <= '0;
            end else if (state_reg == S_FETCH) begin
                k_reg <= k_reg + LEN_W'(1);
            end
            drain_cnt_reg <= (state_reg == S_DRAIN) ? ~drain_cnt_reg : 1'b0;
            // Buffer data arrives one cycle after the strobe; anything else feeds zeros to the PE.
            rd_pend_reg <= (state_reg == S_FETCH);
            inputa_reg  <= rd_pend_reg ? rd_data_a : '0;
            inputb_reg  <= rd_pend_reg ? rd_data_b : '0;
            // INIT spends its first cycle arming the stale-sum clear, its second issuing it.
            out_en_reg    <= (state_reg == S_INIT && !out_en_reg) || (state_next == S_FLUSH);
            res_valid_reg <= (state_next == S_HOLD);
            busy_reg      <= (state_next != S_IDLE);
            if (state_reg == S_CAPTURE) res_data_reg <= res_capture;
        end
    end

    assign start_ready   = (state_reg == S_IDLE);
    assign rd_en         = (state_reg == S_FETCH);
    assign rd_addr_a     = rd_en ? base_a_reg + ADDR_W'(k_reg) : '0;
    assign rd_addr_b     = rd_en ? base_b_reg + ADDR_W'(k_reg) : '0;
    assign mac_inputa    = inputa_reg;
    assign mac_inputb    = inputb_reg;
    assign mac_output_en = out_en_reg;
    assign res_valid     = res_valid_reg;
    assign res_data      = res_data_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: buffer and PE models plus a per-job reference result and cycle schedule.
`timescale 1ns/1ps
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [11:0] start_len;
    logic [9:0]  start_base_a;
    logic [9:0]  start_base_b;
    logic        rd_en;
    logic [9:0]  rd_addr_a;
    logic [9:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] mac_inputa;
    logic [15:0] mac_inputb;
    logic        mac_output_en;
    logic [15:0] mac_result = 16'h0000;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
        .start_base_a(start_base_a), .start_base_b(start_base_b),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mac_inputa(mac_inputa), .mac_inputb(mac_inputb), .mac_output_en(mac_output_en),
        .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    // Buffers: 1-cycle read latency, junk on the bus when no read was issued.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end else begin
            rd_data_a <= 16'($urandom);
            rd_data_b <= 16'($urandom);
        end
    end

    // PE: accumulates the upper half of the unsigned product; output_en dumps and clears.
    logic [15:0] pe_acc = 16'h5A5A;
    logic [31:0] pe_prod;
    assign pe_prod = {16'h0000, mac_inputa} * {16'h0000, mac_inputb};
    always @(posedge clk) begin
        if (mac_output_en) begin
            mac_result <= pe_acc;
            pe_acc     <= 16'h0000;
        end else begin
            pe_acc <= pe_acc + pe_prod[31:16];
        end
    end

    function automatic logic [15:0] model_result(input int len, input logic [9:0] ba, input logic [9:0] bb);
        logic [15:0] acc;
        logic [31:0] p;
        acc = 16'h0000;
        for (int k = 0; k < len; k++) begin
            p = 32'(mem_a[ba + 10'(k)]) * 32'(mem_b[bb + 10'(k)]);
            acc = acc + p[31:16];
        end
`ifdef MAC_SEQ_RELU_EN
        if (acc[15]) acc = 16'h0000;
`endif
        return acc;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk_bit({tag, "_start_ready"}, start_ready, 1'b0);
        chk_bit({tag, "_rd_en"}, rd_en, 1'b0);
        chk_addr({tag, "_rd_addr_a"}, rd_addr_a, 10'h000);
        chk_addr({tag, "_rd_addr_b"}, rd_addr_b, 10'h000);
        chk_word({tag, "_inputa"}, mac_inputa, 16'h0000);
        chk_word({tag, "_inputb"}, mac_inputb, 16'h0000);
        chk_bit({tag, "_output_en"}, mac_output_en, 1'b0);
        chk_bit({tag, "_res_valid"}, res_valid, 1'b0);
        chk_word({tag, "_res_data"}, res_data, 16'h0000);
        chk_bit({tag, "_busy"}, busy, 1'b0);
    endtask

    // Expects exactly one clear pulse with start_ready low, then start_ready high the cycle after.
    task automatic init_check();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_bit("init_rd_en", rd_en, 1'b0);
            chk_bit("init_res_valid", res_valid, 1'b0);
            if (mac_output_en === 1'b1) begin
                pulses++;
                chk_bit("init_ready_low", start_ready, 1'b0);
                at = c;
            end else if (at >= 0) begin
                chk_bit("init_then_ready", start_ready, 1'b1);
                chk_bit("init_then_idle", busy, 1'b0);
                break;
            end
        end
        chk_word("init_pulse_count", 16'(pulses), 16'd1);
        $display("init: clear pulses=%0d", pulses);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        init_check();
    endtask

    // Issues a job from IDLE (called at a negedge) and checks every cycle against the schedule.
    task automatic run_job(input int len, input logic [9:0] ba, input logic [9:0] bb, input int hold);
        logic [15:0] exp_res;
        logic [15:0] ea;
        logic [15:0] eb;
        exp_res = model_result(len, ba, bb);
        chk_bit("idle_start_ready", start_ready, 1'b1);
        start_valid  = 1'b1;
        start_len    = 12'(len);
        start_base_a = ba;
        start_base_b = bb;
        for (int t = 1; t <= len + 4; t++) begin
            @(negedge clk);
            start_valid  = 1'b1;
            start_len    = 12'($urandom);
            start_base_a = 10'($urandom);
            start_base_b = 10'($urandom);
            chk_bit("rd_en", rd_en, t <= len);
            if (t <= len) begin
                chk_addr("rd_addr_a", rd_addr_a, ba + 10'(t - 1));
                chk_addr("rd_addr_b", rd_addr_b, bb + 10'(t - 1));
            end
            ea = (t >= 3 && t <= len + 2) ? mem_a[ba + 10'(t - 3)] : 16'h0000;
            eb = (t >= 3 && t <= len + 2) ? mem_b[bb + 10'(t - 3)] : 16'h0000;
            chk_word("mac_inputa", mac_inputa, ea);
            chk_word("mac_inputb", mac_inputb, eb);
            chk_bit("mac_output_en", mac_output_en, t == len + 3);
            chk_bit("res_valid_early", res_valid, 1'b0);
            chk_bit("busy_ready_low", start_ready, 1'b0);
            chk_bit("busy", busy, 1'b1);
        end
        @(negedge clk);
        start_valid = 1'b0;
        chk_bit("res_valid", res_valid, 1'b1);
        chk_word("res_data", res_data, exp_res);
        chk_bit("hold_ready_low", start_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk_bit("hold_valid", res_valid, 1'b1);
            chk_word("hold_data", res_data, exp_res);
            chk_bit("hold_start_ready", start_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk_bit("after_valid", res_valid, 1'b0);
        chk_bit("after_start_ready", start_ready, 1'b1);
        chk_bit("after_busy", busy, 1'b0);
        $display("job len=%0d base_a=%h base_b=%h hold=%0d result=%h expected=%h",
                 len, ba, bb, hold, res_data, exp_res);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ff_exp;
        rst          = 1'b1;
        start_valid  = 1'b0;
        start_len    = 12'h000;
        start_base_a = 10'h000;
        start_base_b = 10'h000;
        res_ready    = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end

        do_reset();

        for (int k = 0; k < 3; k++) begin
            mem_a[k] = 16'h0100;
            mem_b[k] = 16'h0100;
        end
        run_job(3, 10'h000, 10'h000, 0);
        chk_word("len3_const", res_data, 16'h0003);

        run_job(0, 10'h123, 10'h045, 0);
        chk_word("len0_const", res_data, 16'h0000);

        run_job(2, 10'h010, 10'h020, 10);

        run_job(4, 10'h3FE, 10'h100, 1);

        // Abort a long job mid-fetch, then confirm the next job sees a clean accumulator.
        start_valid  = 1'b1;
        start_len    = 12'd20;
        start_base_a = 10'h050;
        start_base_b = 10'h070;
        repeat (5) @(negedge clk);
        start_valid = 1'b0;
        chk_bit("abort_in_fetch", rd_en, 1'b1);
        do_reset();
        mem_a[10'h060] = 16'h0100;
        mem_b[10'h060] = 16'h0100;
        run_job(1, 10'h060, 10'h060, 0);
        chk_word("after_abort_const", res_data, 16'h0001);

        mem_a[10'h200] = 16'hFFFF;
        mem_b[10'h200] = 16'hFFFF;
`ifdef MAC_SEQ_RELU_EN
        ff_exp = 16'h0000;
`else
        ff_exp = 16'hFFFE;
`endif
        run_job(1, 10'h200, 10'h200, 0);
        chk_word("ffff_const", res_data, ff_exp);

        repeat (12) begin
            run_job(int'($urandom_range(0, 9)), 10'($urandom), 10'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
